// File: rtl/rx_demux_pkg.sv
// Shared PHY definitions: special K-symbol codes and the Rx ordered-set classifier states.
// Used by the Rx demux, OS generator and OS decoder.
package rx_demux_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;

  typedef enum logic [1:0] {
    ST_DATA     = 2'd0,
    ST_COM_PEND = 2'd1,
    ST_IN_SKP   = 2'd2
  } cls_state_e;

  function automatic logic is_ksym(input logic k, input logic [7:0] sym, input logic [7:0] code);
    return k && (sym == code);
  endfunction

endpackage

// File: rtl/rx_demux_if.sv
// Bundle of the PIPE Rx input word and the two demultiplexed output paths.
// master drives the received word; slave is the demux itself.
interface rx_demux_if #(
  parameter int NBYTES = 64
);
  logic                  sel;
  logic [8*NBYTES-1:0]   rx_in;
  logic [NBYTES-1:0]     rx_valid;
  logic [NBYTES-1:0]     rx_datak;
  logic [8*NBYTES-1:0]   data_out;
  logic [NBYTES-1:0]     data_valid;
  logic [NBYTES-1:0]     data_datak;
  logic [8*NBYTES-1:0]   os_out;
  logic [NBYTES-1:0]     os_valid;
  logic [NBYTES-1:0]     os_datak;
  logic [7:0]            skp_count;
  logic                  os_err;

  modport master (
    output sel, rx_in, rx_valid, rx_datak,
    input  data_out, data_valid, data_datak, os_out, os_valid, os_datak, skp_count, os_err
  );

  modport slave (
    input  sel, rx_in, rx_valid, rx_datak,
    output data_out, data_valid, data_datak, os_out, os_valid, os_datak, skp_count, os_err
  );
endinterface

// File: rtl/rx_byte_classify.sv
// One combinational step of the ordered-set classifier: consumes one lane and
// yields the state seen by the next lane plus routing / SKP / error flags.
module rx_byte_classify
  import rx_demux_pkg::*;
(
  input  cls_state_e  state_i,
  input  logic [7:0]  sym_i,
  input  logic        k_i,
  input  logic        valid_i,
  output cls_state_e  state_o,
  output logic        to_os_o,
  output logic        skp_inc_o,
  output logic        err_o
);

  logic is_com;
  logic is_skp;

  assign is_com = is_ksym(k_i, sym_i, COM_SYM);
  assign is_skp = is_ksym(k_i, sym_i, SKP_SYM);

  always_comb begin
    state_o   = state_i;
    to_os_o   = 1'b0;
    skp_inc_o = 1'b0;
    err_o     = 1'b0;
    // Invalid lanes are transparent: state passes straight to the next lane.
    if (valid_i) begin
      case (state_i)
        ST_DATA: begin
          if (is_com) begin
            to_os_o = 1'b1;
            state_o = ST_COM_PEND;
          end else begin
            state_o = ST_DATA;
          end
        end
        ST_COM_PEND: begin
          if (is_skp) begin
            to_os_o   = 1'b1;
            skp_inc_o = 1'b1;
            state_o   = ST_IN_SKP;
          end else if (is_com) begin
            to_os_o = 1'b1;
            err_o   = 1'b1;
            state_o = ST_COM_PEND;
          end else begin
            err_o   = 1'b1;
            state_o = ST_DATA;
          end
        end
        ST_IN_SKP: begin
          if (is_skp) begin
            to_os_o = 1'b1;
            state_o = ST_IN_SKP;
          end else if (is_com) begin
            to_os_o = 1'b1;
            state_o = ST_COM_PEND;
          end else begin
            state_o = ST_DATA;
          end
        end
        default: state_o = ST_DATA;
      endcase
    end
  end

endmodule

// File: rtl/rx_demux.sv
// Rx byte demultiplexer: splits each PIPE Rx word between the LPIF data path and
// the ordered-set decoder path, counting SKP ordered sets seen in the data phase.
module rx_demux
  import rx_demux_pkg::*;
#(
  parameter int NBYTES = 64
) (
  input  logic       clk,
  input  logic       reset,
  rx_demux_if.slave  bus
);

  localparam int W = 8 * NBYTES;

  cls_state_e        state_q, state_d;
  cls_state_e        lane_state [NBYTES+1];
  logic [NBYTES-1:0] lane_os;
  logic [NBYTES-1:0] lane_inc;
  logic [NBYTES-1:0] lane_err;

  logic [W-1:0]      data_out_q, data_out_d;
  logic [NBYTES-1:0] data_valid_q, data_valid_d;
  logic [NBYTES-1:0] data_datak_q, data_datak_d;
  logic [W-1:0]      os_out_q, os_out_d;
  logic [NBYTES-1:0] os_valid_q, os_valid_d;
  logic [NBYTES-1:0] os_datak_q, os_datak_d;
  logic [7:0]        skp_count_q, skp_count_d;
  logic              os_err_q, os_err_d;
  logic [15:0]       inc_total;
  logic [16:0]       skp_sum;

  assign lane_state[0] = state_q;

  // Lanes are classified in ascending order; each stage sees its predecessor's state.
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
      rx_byte_classify u_classify (
        .state_i   (lane_state[gi]),
        .sym_i     (bus.rx_in[8*gi +: 8]),
        .k_i       (bus.rx_datak[gi]),
        .valid_i   (bus.rx_valid[gi]),
        .state_o   (lane_state[gi+1]),
        .to_os_o   (lane_os[gi]),
        .skp_inc_o (lane_inc[gi]),
        .err_o     (lane_err[gi])
      );
    end
  endgenerate

  always_comb begin
    data_out_d   = '0;
    data_valid_d = '0;
    data_datak_d = '0;
    os_out_d     = '0;
    os_valid_d   = '0;
    os_datak_d   = '0;
    inc_total    = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.rx_valid[i]) begin
        if (!bus.sel || lane_os[i]) begin
          os_out_d[8*i +: 8] = bus.rx_in[8*i +: 8];
          os_valid_d[i]      = 1'b1;
          os_datak_d[i]      = bus.rx_datak[i];
        end else begin
          data_out_d[8*i +: 8] = bus.rx_in[8*i +: 8];
          data_valid_d[i]      = 1'b1;
          data_datak_d[i]      = bus.rx_datak[i];
        end
      end
      if (bus.sel) begin
        inc_total = inc_total + 16'(lane_inc[i]);
      end
    end
    skp_sum     = 17'(skp_count_q) + 17'(inc_total);
    skp_count_d = (skp_sum > 17'd255) ? 8'hFF : skp_sum[7:0];
    os_err_d    = bus.sel && (|lane_err);
    // Leaving the data phase drops any half-seen SKP OS silently.
    state_d     = bus.sel ? lane_state[NBYTES] : ST_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DATA;
      data_out_q   <= '0;
      data_valid_q <= '0;
      data_datak_q <= '0;
      os_out_q     <= '0;
      os_valid_q   <= '0;
      os_datak_q   <= '0;
      skp_count_q  <= '0;
      os_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_datak_q <= data_datak_d;
      os_out_q     <= os_out_d;
      os_valid_q   <= os_valid_d;
      os_datak_q   <= os_datak_d;
      skp_count_q  <= skp_count_d;
      os_err_q     <= os_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data_datak = data_datak_q;
  assign bus.os_out     = os_out_q;
  assign bus.os_valid   = os_valid_q;
  assign bus.os_datak   = os_datak_q;
  assign bus.skp_count  = skp_count_q;
  assign bus.os_err     = os_err_q;

endmodule

// File: tb/tb_rx_demux.sv
// Bench for rx_demux: rule-based reference model checked every cycle, plus
// directed words with literal expectations.
module tb_rx_demux;

  localparam int NB = 64;
  localparam int W  = 8 * NB;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  rx_demux_if #(.NBYTES(NB)) bus ();

  rx_demux #(.NBYTES(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte's route depends only on the previous valid byte's role
  // in the data phase ("D" plain data, "C" a COM on the OS path, "S" an OS SKP).
  logic [W-1:0]  exp_data, exp_os;
  logic [NB-1:0] exp_dv, exp_dk, exp_ov, exp_ok;
  int            exp_skp;
  logic          exp_err;
  byte           prev_tag;
  bit            model_armed = 1'b0;

  always @(posedge clk) begin
    logic [7:0] s;
    logic       k;
    logic       to_os;
    exp_data = '0; exp_os = '0; exp_dv = '0; exp_dk = '0; exp_ov = '0; exp_ok = '0;
    exp_err  = 1'b0;
    if (reset) begin
      exp_skp  = 0;
      prev_tag = "D";
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (bus.rx_valid[i]) begin
          s = bus.rx_in[8*i +: 8];
          k = bus.rx_datak[i];
          if (!bus.sel) begin
            to_os = 1'b1;
          end else if (k && s == K_COM) begin
            to_os = 1'b1;
            if (prev_tag == "C") exp_err = 1'b1;
            prev_tag = "C";
          end else if (k && s == K_SKP && prev_tag != "D") begin
            to_os = 1'b1;
            if (prev_tag == "C") exp_skp = (exp_skp >= 255) ? 255 : exp_skp + 1;
            prev_tag = "S";
          end else begin
            to_os = 1'b0;
            if (prev_tag == "C") exp_err = 1'b1;
            prev_tag = "D";
          end
          if (to_os) begin
            exp_os[8*i +: 8] = s; exp_ov[i] = 1'b1; exp_ok[i] = k;
          end else begin
            exp_data[8*i +: 8] = s; exp_dv[i] = 1'b1; exp_dk[i] = k;
          end
        end
      end
      if (!bus.sel) prev_tag = "D";
    end
    model_armed = 1'b1;
  end

  always @(negedge clk) begin
    if (model_armed) begin
      chk("data_out",   bus.data_out,   exp_data);
      chk("data_valid", W'(bus.data_valid), W'(exp_dv));
      chk("data_datak", W'(bus.data_datak), W'(exp_dk));
      chk("os_out",     bus.os_out,     exp_os);
      chk("os_valid",   W'(bus.os_valid),   W'(exp_ov));
      chk("os_datak",   W'(bus.os_datak),   W'(exp_ok));
      chk("skp_count",  W'(bus.skp_count),  W'(exp_skp[7:0]));
      chk("os_err",     W'(bus.os_err),     W'(exp_err));
    end
  end

  // Word under construction; default is every lane valid D byte = lane index.
  logic [W-1:0]  w_data;
  logic [NB-1:0] w_valid, w_k;

  task automatic clear_word();
    for (int i = 0; i < NB; i++) w_data[8*i +: 8] = 8'(i);
    w_valid = '1;
    w_k     = '0;
  endtask

  task automatic put(input int lane, input logic [7:0] s, input logic k);
    w_data[8*lane +: 8] = s;
    w_k[lane]           = k;
    w_valid[lane]       = 1'b1;
  endtask

  task automatic send(input logic s);
    bus.sel      = s;
    bus.rx_in    = w_data;
    bus.rx_valid = w_valid;
    bus.rx_datak = w_k;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] saved;
    reset = 1'b1;
    clear_word();
    send(1'b1);
    send(1'b1);
    reset = 1'b0;
    chk("reset_os_valid", W'(bus.os_valid), '0);
    chk("reset_skp", W'(bus.skp_count), '0);
    $display("txn reset: outputs cleared");

    // sel=0: everything to the OS path
    for (int i = 0; i < NB; i++) begin
      w_data[8*i +: 8] = 8'($urandom);
      w_k[i] = 1'($urandom);
    end
    w_valid = '1;
    saved = w_data;
    send(1'b0);
    chk("sel0_os_out", bus.os_out, saved);
    chk("sel0_os_valid", W'(bus.os_valid), W'({NB{1'b1}}));
    chk("sel0_data_valid", W'(bus.data_valid), '0);
    $display("txn sel0 random word");

    // BC,1C,1C,1C then data
    do_reset();
    clear_word();
    put(0, K_COM, 1'b1); put(1, K_SKP, 1'b1); put(2, K_SKP, 1'b1); put(3, K_SKP, 1'b1);
    send(1'b1);
    chk("skp4_os_valid", W'(bus.os_valid), W'(64'h000000000000000F));
    chk("skp4_data_valid", W'(bus.data_valid), W'(64'hFFFFFFFFFFFFFFF0));
    chk("skp4_skp_count", W'(bus.skp_count), W'(8'd1));
    $display("txn sel1 SKP OS in lanes 0-3");

    // SKP OS split across words
    do_reset();
    clear_word();
    put(63, K_COM, 1'b1);
    send(1'b1);
    chk("split_c1_os_valid", W'(bus.os_valid), W'(64'h8000000000000000));
    clear_word();
    put(0, K_SKP, 1'b1); put(1, K_SKP, 1'b1); put(2, K_SKP, 1'b1);
    send(1'b1);
    chk("split_c2_os_valid", W'(bus.os_valid), W'(64'h0000000000000007));
    chk("split_skp_count", W'(bus.skp_count), W'(8'd1));
    chk("split_os_err", W'(bus.os_err), '0);
    $display("txn SKP OS split across word boundary");

    // COM followed by data byte
    do_reset();
    clear_word();
    put(0, K_COM, 1'b1); put(1, 8'h00, 1'b0);
    send(1'b1);
    chk("comerr_os_byte", W'(bus.os_out[7:0]), W'(K_COM));
    chk("comerr_data_valid1", W'(bus.data_valid[1]), W'(1'b1));
    chk("comerr_data_byte1", W'(bus.data_out[15:8]), W'(8'h00));
    chk("comerr_os_err", W'(bus.os_err), W'(1'b1));
    clear_word();
    send(1'b1);
    chk("comerr_pulse_end", W'(bus.os_err), '0);
    $display("txn COM followed by D byte");

    // invalid lanes inside a SKP OS
    do_reset();
    clear_word();
    put(3, K_COM, 1'b1);
    w_valid[7:4] = 4'h0;
    put(8, K_SKP, 1'b1);
    send(1'b1);
    chk("gap_os_valid", W'(bus.os_valid), W'(64'h0000000000000108));
    chk("gap_data_valid", W'(bus.data_valid), W'(64'hFFFFFFFFFFFFFE07));
    chk("gap_skp_count", W'(bus.skp_count), W'(8'd1));
    $display("txn invalid lanes inside SKP OS");

    // bubble between COM and SKP
    clear_word(); put(63, K_COM, 1'b1); send(1'b1);
    w_valid = '0; send(1'b1);
    chk("bubble_valid", W'(bus.os_valid | bus.data_valid), '0);
    clear_word(); put(0, K_SKP, 1'b1); send(1'b1);
    chk("bubble_skp_count", W'(bus.skp_count), W'(8'd2));
    $display("txn bubble holds classifier state");

    // sel drops while COM pending
    clear_word(); put(63, K_COM, 1'b1); send(1'b1);
    clear_word(); put(0, K_SKP, 1'b1); send(1'b0);
    chk("seldrop_os_err", W'(bus.os_err), '0);
    clear_word(); put(0, K_SKP, 1'b1); send(1'b1);
    chk("seldrop_skp_data", W'(bus.data_valid[0]), W'(1'b1));
    chk("seldrop_skp_count", W'(bus.skp_count), W'(8'd2));
    $display("txn sel 1->0 discards pending COM");

    // reset in the middle of a SKP OS
    clear_word(); put(63, K_COM, 1'b1); send(1'b1);
    clear_word(); put(0, K_SKP, 1'b1);
    reset = 1'b1; send(1'b1); reset = 1'b0;
    chk("rstmid_os_valid", W'(bus.os_valid), '0);
    send(1'b1);
    chk("rstmid_skp_on_data", W'(bus.data_valid[0]), W'(1'b1));
    chk("rstmid_skp_count", W'(bus.skp_count), '0);
    $display("txn reset abandons partial SKP OS");

    // 300 SKP OS -> saturation
    do_reset();
    for (int wd = 0; wd < 19; wd++) begin
      clear_word();
      for (int g = 0; g < 16; g++) begin
        if (wd < 18 || g < 12) begin
          put(4*g, K_COM, 1'b1); put(4*g+1, K_SKP, 1'b1);
          put(4*g+2, K_SKP, 1'b1); put(4*g+3, K_SKP, 1'b1);
        end
      end
      send(1'b1);
    end
    chk("sat_skp_count", W'(bus.skp_count), W'(8'hFF));
    do_reset();
    chk("sat_rst_skp", W'(bus.skp_count), '0);
    chk("sat_rst_out", bus.os_out | bus.data_out, '0);
    $display("txn 300 SKP OS saturate, then reset");

    // random mix, checked by the model
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 3))
          0: begin w_data[8*i +: 8] = K_COM; w_k[i] = 1'b1; end
          1: begin w_data[8*i +: 8] = K_SKP; w_k[i] = 1'b1; end
          2: begin w_data[8*i +: 8] = 8'($urandom); w_k[i] = 1'b0; end
          default: begin w_data[8*i +: 8] = 8'($urandom); w_k[i] = 1'($urandom); end
        endcase
        w_valid[i] = ($urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 19) == 0) w_valid = '0;
      reset = ($urandom_range(0, 49) == 0);
      send($urandom_range(0, 6) != 0);
      $display("txn random %0d: ov=%h dv=%h skp=%0d err=%0d",
               t, bus.os_valid, bus.data_valid, bus.skp_count, bus.os_err);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_demux.md
RX_DEMUX -- requirements
Module: rx_demux

Interface
REQ-001 SHALL have parameter NBYTES, default 64, giving the byte lanes per word; the data width is 8*NBYTES.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sel, input, 1 bit: from Rx LTSSM; 1 = L0 data phase, 0 = ordered-set phase.
REQ-005 SHALL have port rx_in, input, 8*NBYTES bits: received bytes from the PIPE Rx side; byte i is rx_in[8i+7:8i].
REQ-006 SHALL have port rx_valid, input, NBYTES bits: per-byte valid.
REQ-007 SHALL have port rx_datak, input, NBYTES bits: per-byte K (1) or D (0) flag.
REQ-008 SHALL have ports data_out (8*NBYTES), data_valid (NBYTES) and data_datak (NBYTES), outputs: bytes bound for LPIF Rx control and dataflow.
REQ-009 SHALL have ports os_out (8*NBYTES), os_valid (NBYTES) and os_datak (NBYTES), outputs: bytes bound for the OS decoder.
REQ-010 SHALL have port skp_count, output, 8 bits: saturating count of SKP ordered sets detected in data phase.
REQ-011 SHALL have port os_err, output, 1 bit: one-cycle pulse when a data-phase COM is not followed by SKP.

Function
REQ-012 SHALL register all outputs: byte i of the input word appears on exactly one output path one clk after capture.
REQ-013 SHALL keep each byte at its input lane index on the chosen path; on the other path that lane has valid=0, data=0 and datak=0.
REQ-014 SHALL drive os_valid=0 and data_valid=0 for lanes where rx_valid=0; invalid lanes are skipped by the classifier and do not change its state.
REQ-015 SHALL route every valid byte to the OS path when sel=0, and force the classifier state to DATA.
REQ-016 SHALL, when sel=1, classify valid bytes in ascending lane order with the state machine DATA / COM_PEND / IN_SKP, carrying state across words.
REQ-017 SHALL handle state DATA as follows:
- K byte 8'hBC (COM): route to OS, go to COM_PEND.
- Any other byte: route to data path, stay in DATA.
REQ-018 SHALL handle state COM_PEND as follows:
- K byte 8'h1C (SKP): route to OS, go to IN_SKP, increment skp_count.
- K 8'hBC: route to OS, pulse os_err, stay in COM_PEND.
- Any other byte: route to data path, pulse os_err, go to DATA.
REQ-019 SHALL handle state IN_SKP as follows:
- K 8'h1C: route to OS, stay in IN_SKP.
- K 8'hBC: route to OS, go to COM_PEND (back-to-back SKP OS).
- Any other byte: route to data path, go to DATA.
REQ-020 SHALL pulse os_err for one cycle, registered with the word, if one or more errors occur within a word.
REQ-021 SHALL saturate skp_count at 8'hFF; at most NBYTES/2 increments are possible per word, summed with saturation.
REQ-022 SHALL, when sel changes, apply the new sel value to the whole word captured in that cycle; a 1-to-0 transition discards pending COM_PEND/IN_SKP state without raising os_err.
REQ-023 SHALL treat an all-invalid word as a bubble: both paths show valid=0 and the state is held.

Reset
REQ-024 SHALL, on reset=1 at a clk edge, clear all data/valid/datak outputs, skp_count and os_err to 0 and set the state to DATA.
REQ-025 SHALL discard the word captured in a reset cycle, so that outputs are 0 in the following cycle.
REQ-026 SHALL abandon a partially received SKP OS interrupted by reset without raising os_err or incrementing skp_count.

Structure
REQ-027 SHALL take the COM (8'hBC) and SKP (8'h1C) symbol constants and the classifier state enumeration from the shared PHY package, which is also used by the OS generator and OS decoder.
REQ-028 SHALL implement the per-byte classify step (state, byte, k, valid -> next state, route, skp_inc, err) as one combinational sub-module, rx_byte_classify, chained NBYTES times.

Verification
REQ-029 SHALL cover: sel=0, all lanes valid, random bytes -> next cycle os_out==rx_in, os_valid=all-ones, data_valid=0.
REQ-030 SHALL cover: sel=1, lanes 0-3 = K BC,1C,1C,1C and the rest D -> os_valid=64'h000000000000000F, data_valid=64'hFFFFFFFFFFFFFFF0, skp_count=1.
REQ-031 SHALL cover: sel=1, lane 63 = K BC, then the next word with lanes 0-2 = K 1C -> os_valid bit 63 set in cycle 1 and bits 0-2 set in cycle 2, skp_count=1, os_err=0.
REQ-032 SHALL cover: sel=1, K BC followed by D 8'h00 -> COM on the OS path, 8'h00 on the data path, os_err pulses once.
REQ-033 SHALL cover: sel=1, 300 SKP OS -> skp_count saturates at 8'hFF; then reset -> skp_count=0 and all outputs 0.
REQ-034 SHALL cover: sel=1, lanes 4-7 invalid in the middle of BC,[invalid],1C -> invalid lanes are skipped and the SKP OS is still counted.
